// File: rtl/rect_drawer_if.sv
// Bundles the command, pixel-stream and status signals of the rectangle raster generator.
// Latency: none; it only carries wires.
// Backpressure: ready from the slave's point of view is an input; valid/x/y hold while ready is low.
//   master: issues start/x0/y0/w/h/mode, drives ready, observes x/y/valid/busy/done
//   slave : the rectangle generator itself
interface rect_drawer_if #(
  parameter int CW = 11
);
  logic          start;
  logic [CW-1:0] x0;
  logic [CW-1:0] y0;
  logic [CW-1:0] w;
  logic [CW-1:0] h;
  logic          mode;
  logic          ready;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          valid;
  logic          busy;
  logic          done;

  modport master (
    output start, x0, y0, w, h, mode, ready,
    input  x, y, valid, busy, done
  );

  modport slave (
    input  start, x0, y0, w, h, mode, ready,
    output x, y, valid, busy, done
  );
endinterface

// File: rtl/rect_drawer.sv
// Rectangle raster generator: streams pixel coordinates row-major (x fastest), filled or outline.
// Latency: first pixel valid one cycle after start is sampled in IDLE; one pixel per accepted cycle.
// Backpressure: x/y/valid hold while valid && !ready; done pulses one cycle after the last transfer.
//   clk, reset : clock and synchronous active-high reset
//   bus        : rect_drawer_if.slave (command in, pixel stream out, busy/done status)
module rect_drawer #(
  parameter int CW = 11
) (
  input  logic         clk,
  input  logic         reset,
  rect_drawer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] x0_q, y0_q, w_q, h_q;
  logic [CW-1:0] x0_n, y0_n, w_n, h_n;
  logic          mode_q, mode_n;
  logic [CW-1:0] cx, cy, cx_n, cy_n;
  logic [CW-1:0] x_q, y_q, x_n, y_n;

  logic last_col, last_row, edge_row;

  // Termination is decided on the counters only, so coordinates may wrap freely.
  assign last_col = (cx == w_q - CW'(1));
  assign last_row = (cy == h_q - CW'(1));
  assign edge_row = (cy == '0) || last_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      x0_q   <= '0;
      y0_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      mode_q <= 1'b0;
      cx     <= '0;
      cy     <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      state  <= state_n;
      x0_q   <= x0_n;
      y0_q   <= y0_n;
      w_q    <= w_n;
      h_q    <= h_n;
      mode_q <= mode_n;
      cx     <= cx_n;
      cy     <= cy_n;
      x_q    <= x_n;
      y_q    <= y_n;
    end
  end

  always_comb begin
    state_n = state;
    x0_n    = x0_q;
    y0_n    = y0_q;
    w_n     = w_q;
    h_n     = h_q;
    mode_n  = mode_q;
    cx_n    = cx;
    cy_n    = cy;
    x_n     = x_q;
    y_n     = y_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          x0_n   = bus.x0;
          y0_n   = bus.y0;
          w_n    = bus.w;
          h_n    = bus.h;
          mode_n = bus.mode;
          cx_n   = '0;
          cy_n   = '0;
          // An empty rectangle skips DRAW; x/y keep their previous values.
          if (bus.w == '0 || bus.h == '0) begin
            state_n = FINISH;
          end else begin
            state_n = DRAW;
            x_n     = bus.x0;
            y_n     = bus.y0;
          end
        end
      end

      DRAW: begin
        if (bus.ready) begin
          if (last_row && last_col) begin
            // Final pixel accepted: leave x/y on it and stop.
            state_n = FINISH;
          end else begin
            if (mode_q && !edge_row && cx == '0 && !last_col) begin
              // Outline interior row: skip straight from left to right edge.
              cx_n = w_q - CW'(1);
            end else if (last_col) begin
              cx_n = '0;
              cy_n = cy + CW'(1);
            end else begin
              cx_n = cx + CW'(1);
            end
            x_n = x0_q + cx_n;
            y_n = y0_q + cy_n;
          end
        end
      end

      FINISH: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.valid = (state == DRAW);
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == FINISH);

endmodule

// File: tb/tb_rect_drawer.sv
// Bench for rect_drawer: directed and random rectangles checked against a loop-based pixel list.
// Latency: expects first pixel one cycle after start, done one cycle after the last transfer.
// Backpressure: drives ready constant, random or 1,0,0 patterned; expects stalled pixels to hold.
module tb_rect_drawer;
  localparam int CW     = 11;
  localparam int BUDGET = 2000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int nvec = 0;
  int nerr = 0;

  logic [2*CW-1:0] exp_q[$];

  rect_drawer_if #(.CW(CW)) bus ();

  rect_drawer #(.CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: every pixel of the w x h box in raster order, keeping only the border in outline mode.
  task automatic build_model(input int ax0, input int ay0, input int aw, input int ah, input int am);
    exp_q.delete();
    for (int r = 0; r < ah; r++)
      for (int c = 0; c < aw; c++)
        if (am == 0 || r == 0 || r == ah - 1 || c == 0 || c == aw - 1)
          exp_q.push_back({CW'(ax0 + c), CW'(ay0 + r)});
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0 repeating.
  // noise: keep poking start with a different command while the rectangle is drawn.
  task automatic run_rect(input int ax0, input int ay0, input int aw, input int ah, input int am,
                          input int rdy_mode, input bit noise);
    int cyc;
    bit rdy;
    build_model(ax0, ay0, aw, ah, am);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x0    = CW'(ax0);
    bus.y0    = CW'(ay0);
    bus.w     = CW'(aw);
    bus.h     = CW'(ah);
    bus.mode  = am[0];
    @(negedge clk);
    bus.start = 1'b0;
    bus.x0    = CW'($urandom);
    bus.y0    = CW'($urandom);
    bus.w     = CW'($urandom);
    bus.h     = CW'($urandom);
    bus.mode  = 1'($urandom);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < BUDGET) begin
      chk("valid", 32'(bus.valid), 32'd1);
      chk("pixel_xy", 32'({bus.x, bus.y}), 32'(exp_q[0]));
      chk("busy_draw", 32'(bus.busy), 32'd1);
      chk("done_early", 32'(bus.done), 32'd0);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc % 3 == 0);
      endcase
      bus.ready = rdy;
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.x0    = CW'(100);
        bus.w     = CW'($urandom_range(1, 7));
        bus.h     = CW'($urandom_range(1, 7));
      end
      @(negedge clk);
      if (rdy) void'(exp_q.pop_front());
      cyc++;
    end
    if (exp_q.size() > 0) chk("draw_timeout", 32'(exp_q.size()), 32'd0);
    bus.start = 1'b0;
    bus.ready = 1'($urandom_range(0, 1));
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("valid_finish", 32'(bus.valid), 32'd0);
    chk("busy_finish", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("done_once", 32'(bus.done), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("valid_idle", 32'(bus.valid), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x0    = '0;
    bus.y0    = '0;
    bus.w     = '0;
    bus.h     = '0;
    bus.mode  = 1'b0;
    bus.ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_xy", 32'({bus.x, bus.y}), 32'd0);
    reset = 1'b0;

    // Directed cases.
    run_rect(20, 20, 3, 2, 0, 0, 1'b0);     // filled 3x2
    run_rect(0, 0, 4, 4, 1, 0, 1'b0);       // outline 4x4, 12 pixels
    run_rect(5, 7, 2, 2, 0, 2, 1'b0);       // filled 2x2 under backpressure
    run_rect(0, 0, 0, 5, 0, 0, 1'b0);       // zero width
    run_rect(9, 9, 3, 3, 0, 0, 1'b1);       // start ignored mid-draw
    run_rect(2046, 0, 4, 1, 0, 0, 1'b0);    // x wraps 2046,2047,0,1
    run_rect(10, 2047, 1, 5, 1, 1, 1'b0);   // outline w==1, y wraps
    run_rect(30, 40, 5, 3, 1, 1, 1'b1);     // outline with noise and random ready

    // Random rectangles.
    for (int i = 0; i < 25; i++)
      run_rect(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    // Reset after three pixels of a 5x5: outputs clear and no done follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.x0    = CW'(50);
    bus.y0    = CW'(60);
    bus.w     = CW'(5);
    bus.h     = CW'(5);
    bus.mode  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_xy", 32'({bus.x, bus.y}), 32'({CW'(53), CW'(60)}));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_xy", 32'({bus.x, bus.y}), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({bus.valid, bus.busy, bus.done}), 32'd0);
    end

    // A fresh command still works after the abort.
    run_rect(1, 2, 2, 3, 0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rect_drawer.md
Name: rect_drawer

Overview:
Parametrised rectangle raster generator, successor to the fixed-size square drawer. On a start pulse it latches origin, width, height and mode. It then streams pixel coordinates in raster order (row-major, x fastest) over a valid/ready handshake to the frame-buffer writer. It supports filled and outline modes, runtime sizes including zero, and downstream backpressure.

Parameters:
CW, 11, coordinate and size width in bits (x0, y0, w, h, x, y).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
x0  input  CW  left column of rectangle
y0  input  CW  top row of rectangle
w  input  CW  width in pixels (0 allowed)
h  input  CW  height in pixels (0 allowed)
mode  input  1  0 = filled, 1 = outline only
ready  input  1  downstream accepts current pixel this cycle
x  output  CW  pixel column
y  output  CW  pixel row
valid  output  1  x/y hold a pixel to be written
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the rectangle completes

Behaviour:
- Clock clk; reset is synchronous and active-high.
- States: IDLE, DRAW, FINISH.
- Reset values: state=IDLE, x=0, y=0, valid=0, busy=0, done=0.
- Reset mid-operation: at the next edge, return to IDLE with all outputs at reset values. No further pixels are emitted.
- IDLE with start=1:
  - Latch x0, y0, w, h, mode into internal registers. Inputs may change afterwards without effect.
  - If w==0 or h==0, go to FINISH; no pixel is ever valid.
  - Otherwise go to DRAW, with x=x0, y=y0, valid=1 in the first DRAW cycle. Latency is 1 cycle from start sampled to first valid pixel.
- start is ignored in DRAW and FINISH. A new command is only accepted from IDLE.
- Internal counters: column cx in 0..w-1 and row cy in 0..h-1, each CW bits.
  - x = x0_latched + cx, truncated to CW bits (wraps modulo 2^CW).
  - y = y0_latched + cy, truncated the same way.
  - Termination uses the counters, never coordinate compares, so wrap-around is harmless.
- Transfer occurs on a rising edge where valid && ready.
  - If valid && !ready, x, y and valid hold unchanged.
- Advance on transfer, filled mode:
  - cx++ while cx<w-1.
  - Else cx=0 and cy++.
- Advance on transfer, outline mode:
  - On row 0 or row h-1, advance as in filled mode.
  - On interior rows: from cx=0 jump to cx=w-1; from cx=w-1 go to cx=0 and cy++.
  - If w==1, each interior row emits one pixel (cx=0 is also w-1).
- Pixel counts:
  - Filled: w*h.
  - Outline: w*h when w<=2 or h<=2, else 2w+2(h-2).
  - No pixel is emitted twice.
- Last transfer (final pixel accepted) moves DRAW to FINISH. valid drops to 0 in the same edge.
- FINISH: done=1 for exactly one cycle, then IDLE. busy=1 in FINISH.
- Outside DRAW, x and y hold their last values; consumers must qualify them with valid.
- valid=1 only in DRAW.

Test Plan:
- Filled, basic: reset; x0=20, y0=20, w=3, h=2, mode=0, start=1 for 1 cycle, ready=1 -> pixels (20,20),(21,20),(22,20),(20,21),(21,21),(22,21) on consecutive cycles; first valid 1 cycle after start; done high exactly 1 cycle, the cycle after the 6th transfer; busy low afterwards.
- Outline: x0=0, y0=0, w=4, h=4, mode=1 -> 12 pixels in order: (0..3,0), (0,1),(3,1), (0,2),(3,2), (0..3,3); no interior pixel.
- Backpressure: filled 2x2 with ready toggling 1,0,0,1,... -> x/y/valid frozen while ready=0; all 4 pixels delivered exactly once in order; done after the 4th accepted pixel.
- Zero size and busy-ignore: w=0, h=5, start -> valid never asserted, done pulses 1 cycle later. Then start a 3x3, pulse start again mid-draw with x0=100 -> still exactly 9 pixels at the original origin.
- Wrap and reset: x0=2046, w=4, h=1, CW=11 -> x sequence 2046, 2047, 0, 1. Separately, assert reset after 3 pixels of a 5x5 -> next cycle valid=0, busy=0, done=0, x=y=0, and no done pulse.
